// File: rtl/mage_fifo_ctrl.sv
// Parametrised synchronous FIFO controller: fill level, almost flags, sticky ovf/udf.
// Optional zero-latency pass-through when empty, enabled by macro MAGE_FIFO_BYPASS_EN.
module mage_fifo_ctrl #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 8,
   parameter int ALM_FULL_TH  = DEPTH - 2,
   parameter int ALM_EMPTY_TH = 1,
   parameter int CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  alm_full_o,
   output logic                  alm_empty_o,
   output logic [CNT_W-1:0]      usage_o,
   output logic                  ovf_o,
   output logic                  udf_o,
   input  logic                  err_clr_i
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(ALM_FULL_TH);
   localparam logic [CNT_W-1:0] CNT_AEMPT = CNT_W'(ALM_EMPTY_TH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      usage_q;
   logic                  ovf_q, udf_q;
   logic                  push_acc, pop_acc, pass_thru;
   logic                  wr_en, rd_en, ovf_evt, udf_evt;

   // Handshake: push_i is taken when not full, or when full with a same-cycle pop;
   // pop_i is taken only when not empty. Rejected requests raise sticky ovf/udf flags.
   always_comb begin
      push_acc  = push_i & (~full_o | pop_i);
      pop_acc   = pop_i & ~empty_o;
`ifdef MAGE_FIFO_BYPASS_EN
      pass_thru = empty_o & push_i & pop_i;
`else
      pass_thru = 1'b0;
`endif
      wr_en   = push_acc & ~pass_thru & ~flush_i;
      rd_en   = pop_acc & ~flush_i;
      ovf_evt = push_i & full_o & ~pop_i & ~flush_i;
      udf_evt = pop_i & empty_o & ~pass_thru & ~flush_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         usage_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else if (flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         usage_q <= '0;
         ovf_q   <= ovf_q & ~err_clr_i;
         udf_q   <= udf_q & ~err_clr_i;
      end else begin
         if (wr_en) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
         if (wr_en && !rd_en)      usage_q <= usage_q + CNT_W'(1);
         else if (rd_en && !wr_en) usage_q <= usage_q - CNT_W'(1);
         // A new error in the clearing cycle keeps the flag set
         ovf_q <= (ovf_q & ~err_clr_i) | ovf_evt;
         udf_q <= (udf_q & ~err_clr_i) | udf_evt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= data_i;
   end

   always_comb begin
      data_o = '0;
      if (!empty_o) data_o = mem[rd_ptr];
`ifdef MAGE_FIFO_BYPASS_EN
      if (empty_o && push_i) data_o = data_i;
`endif
   end

   assign empty_o     = (usage_q == '0);
   assign full_o      = (usage_q == CNT_FULL);
   assign alm_full_o  = (usage_q >= CNT_AFULL);
   assign alm_empty_o = (usage_q <= CNT_AEMPT);
   assign usage_o     = usage_q;
   assign ovf_o       = ovf_q;
   assign udf_o       = udf_q;

endmodule

// File: tb/tb_mage_fifo_ctrl.sv
// Bench for mage_fifo_ctrl: vector table on a DEPTH=8 instance, hand sequences for
// bypass and a DEPTH=5 queue-scoreboarded burst with an asynchronous reset.
module tb_mage_fifo_ctrl;

`ifdef MAGE_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DEPTH=8 instance
   logic       rst8, push8, pop8, flush8, clr8;
   logic [7:0] din8, dout8;
   logic       empty8, full8, afull8, aempty8, ovf8, udf8;
   logic [3:0] usage8;

   // DEPTH=5 instance
   logic       rst5, push5, pop5, flush5, clr5;
   logic [7:0] din5, dout5;
   logic       empty5, full5, afull5, aempty5, ovf5, udf5;
   logic [2:0] usage5;

   mage_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst8), .push_i(push8), .pop_i(pop8), .flush_i(flush8),
      .data_i(din8), .data_o(dout8), .empty_o(empty8), .full_o(full8),
      .alm_full_o(afull8), .alm_empty_o(aempty8), .usage_o(usage8),
      .ovf_o(ovf8), .udf_o(udf8), .err_clr_i(clr8)
   );

   mage_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(5)) u_dut5 (
      .clk_i(clk), .rst_i(rst5), .push_i(push5), .pop_i(pop5), .flush_i(flush5),
      .data_i(din5), .data_o(dout5), .empty_o(empty5), .full_o(full5),
      .alm_full_o(afull5), .alm_empty_o(aempty5), .usage_o(usage5),
      .ovf_o(ovf5), .udf_o(udf5), .err_clr_i(clr5)
   );

   typedef struct {
      logic       push, pop, flush, clr;
      logic [7:0] din;
      int         exp_usage;
      logic [7:0] exp_data;
      logic       exp_ovf, exp_udf;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic p, input logic r, input logic f, input logic c,
                      input logic [7:0] d, input int eu, input logic [7:0] ed,
                      input logic eo, input logic eud);
      vec_t v;
      v.push = p; v.pop = r; v.flush = f; v.clr = c; v.din = d;
      v.exp_usage = eu; v.exp_data = ed; v.exp_ovf = eo; v.exp_udf = eud;
      vecs.push_back(v);
   endtask

   task automatic idle8();
      push8 = 1'b0; pop8 = 1'b0; flush8 = 1'b0; clr8 = 1'b0; din8 = 8'h00;
   endtask

   task automatic check8(input string tag, input int eu, input logic [7:0] ed,
                         input logic eo, input logic eud);
      check({tag, " usage"},  32'(usage8),  32'(eu));
      check({tag, " data"},   32'(dout8),   32'(ed));
      check({tag, " empty"},  32'(empty8),  32'(eu == 0));
      check({tag, " full"},   32'(full8),   32'(eu == 8));
      check({tag, " afull"},  32'(afull8),  32'(eu >= 6));
      check({tag, " aempty"}, 32'(aempty8), 32'(eu <= 1));
      check({tag, " ovf"},    32'(ovf8),    32'(eo));
      check({tag, " udf"},    32'(udf8),    32'(eud));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pre_data;
      int         sz;
      logic       pass, pacc, racc;

      // Fill, overflow, drain
      for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, 8'(k), k, 8'h01, 0, 0);
      add(1, 0, 0, 0, 8'hAA, 8, 8'h01, 1, 0);
      for (int k = 1; k <= 8; k++) add(0, 1, 0, 0, 8'h00, 8 - k, (k < 8) ? 8'(k + 1) : 8'h00, 1, 0);
      add(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
      // Refill, push+pop while full, drain across the pointer wrap
      for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, 8'(k), k, 8'h01, 0, 0);
      add(1, 1, 0, 0, 8'h09, 8, 8'h02, 0, 0);
      for (int k = 1; k <= 8; k++) add(0, 1, 0, 0, 8'h00, 8 - k, (k < 8) ? 8'(k + 2) : 8'h00, 0, 0);
      // Underflow, then flush with push+pop at usage 5
      add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1);
      for (int k = 1; k <= 5; k++) add(1, 0, 0, 0, 8'(8'h10 + k), k, 8'h11, 0, 1);
      add(1, 1, 1, 0, 8'h77, 0, 8'h00, 0, 1);
      add(1, 0, 0, 0, 8'h33, 1, 8'h33, 0, 1);
      add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1);
      add(0, 1, 0, 1, 8'h00, 0, 8'h00, 0, 1);
      add(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);

      idle8();
      push5 = 1'b0; pop5 = 1'b0; flush5 = 1'b0; clr5 = 1'b0; din5 = 8'h00;
      rst8 = 1'b1; rst5 = 1'b1;
      #12;
      check8("reset8", 0, 8'h00, 0, 0);
      check("reset5 usage", 32'(usage5), 32'd0);
      check("reset5 empty", 32'(empty5), 32'd1);
      @(negedge clk);
      rst8 = 1'b0; rst5 = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         push8 = vecs[i].push; pop8 = vecs[i].pop; flush8 = vecs[i].flush;
         clr8 = vecs[i].clr; din8 = vecs[i].din;
         @(posedge clk);
         #1 idle8();
         #1 check8($sformatf("v%0d", i), vecs[i].exp_usage, vecs[i].exp_data,
                   vecs[i].exp_ovf, vecs[i].exp_udf);
      end

      // Push+pop on empty: pass-through or store with underflow
      @(negedge clk);
      push8 = 1'b1; pop8 = 1'b1; din8 = 8'h55;
      #1 check("bypass comb data", 32'(dout8), BYP ? 32'h55 : 32'h00);
      check("bypass comb usage", 32'(usage8), 32'd0);
      @(posedge clk);
      #1 idle8();
      #1 check8("bypass post", BYP ? 0 : 1, BYP ? 8'h00 : 8'h55, 0, !BYP);
      @(negedge clk);
      pop8 = 1'b1; clr8 = 1'b1;
      @(posedge clk);
      #1 idle8();
      #1 check8("bypass drain", 0, 8'h00, 0, BYP);

      // DEPTH=5 burst against a queue model, async reset mid-burst
      begin
         logic m_ovf = 1'b0;
         logic m_udf = 1'b0;
         for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            push5 = (i < 12) ? 1'b1 : (i % 2 == 1);
            pop5  = (i == 4) || (i == 7) || (i >= 12);
            clr5  = (i == 10) || (i == 20);
            din5  = 8'(8'h40 + i);
            if (i == 16) begin
               #1 rst5 = 1'b1;
               #1 check("rst5 usage", 32'(usage5), 32'd0);
               check("rst5 empty", 32'(empty5), 32'd1);
               check("rst5 full", 32'(full5), 32'd0);
               check("rst5 ovf", 32'(ovf5), 32'd0);
               check("rst5 udf", 32'(udf5), 32'd0);
               check("rst5 data", 32'(dout5), (BYP && push5) ? 32'(din5) : 32'd0);
               #1 rst5 = 1'b0;
               exp_q.delete();
               m_ovf = 1'b0;
               m_udf = 1'b0;
            end
            sz   = exp_q.size();
            pass = BYP && sz == 0 && push5 && pop5;
            pacc = push5 && (sz < 5 || pop5) && !pass;
            racc = pop5 && sz > 0;
            m_ovf = (m_ovf && !clr5) || (push5 && sz == 5 && !pop5);
            m_udf = (m_udf && !clr5) || (pop5 && sz == 0 && !pass);
            if (racc) void'(exp_q.pop_front());
            if (pacc) exp_q.push_back(din5);
            @(posedge clk);
            #1 push5 = 1'b0; pop5 = 1'b0; clr5 = 1'b0; din5 = 8'h00;
            #1;
            sz = exp_q.size();
            pre_data = (sz > 0) ? exp_q[0] : 8'h00;
            check($sformatf("d5 c%0d usage", i), 32'(usage5), 32'(sz));
            check($sformatf("d5 c%0d data", i), 32'(dout5), 32'(pre_data));
            check($sformatf("d5 c%0d full", i), 32'(full5), 32'(sz == 5));
            check($sformatf("d5 c%0d afull", i), 32'(afull5), 32'(sz >= 3));
            check($sformatf("d5 c%0d aempty", i), 32'(aempty5), 32'(sz <= 1));
            check($sformatf("d5 c%0d ovf", i), 32'(ovf5), 32'(m_ovf));
            check($sformatf("d5 c%0d udf", i), 32'(udf5), 32'(m_udf));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
